// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, functs, ALU encoding and R-type decode helper shared by mips_core
package mips_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04, F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07, F_JR = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
  } alu_op_t;
  typedef struct packed {
    logic    ok;
    alu_op_t op;
  } rdec_t;
  function automatic rdec_t rtype_dec(input logic [5:0] f);
    rdec_t d;
    d = '{ok: 1'b1, op: ALU_ADD};
    case (f)
      F_SLL, F_SLLV: d.op = ALU_SLL;
      F_SRL, F_SRLV: d.op = ALU_SRL;
      F_SRA, F_SRAV: d.op = ALU_SRA;
      F_ADD, F_ADDU: d.op = ALU_ADD;
      F_SUB, F_SUBU: d.op = ALU_SUB;
      F_AND: d.op = ALU_AND;
      F_OR: d.op = ALU_OR;
      F_XOR: d.op = ALU_XOR;
      F_NOR: d.op = ALU_NOR;
      F_SLT: d.op = ALU_SLT;
      F_SLTU: d.op = ALU_SLTU;
      default: d.ok = 1'b0;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/mips_if.sv
// mips_if: instruction fetch port and data-bus control signals of mips_core
interface mips_if;
  logic [31:0] ProgramCounter;
  logic [31:0] Instruction;
  logic [31:0] AddressBus;
  logic [31:0] ALUResult;
  logic        MemRead;
  logic        BusCycle;
  logic [3:0]  MemWrite;
  modport master(output ProgramCounter, AddressBus, ALUResult, MemRead, MemWrite, BusCycle, input Instruction);
  modport slave(input ProgramCounter, AddressBus, ALUResult, MemRead, MemWrite, BusCycle, output Instruction);
endinterface

// File: rtl/mips_alu.sv
// mips_alu: combinational ALU; shifts operate on b by shamt
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_t     op,
  output logic [31:0] y
);
  always_comb
    case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR: y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_SLL: y = b << shamt;
      ALU_SRL: y = b >> shamt;
      ALU_SRA: y = $unsigned($signed(b) >>> shamt);
      ALU_PASSB: y = b;
      default: y = a + b;
    endcase
endmodule

// File: rtl/mips_core.sv
// mips_core: single-cycle MIPS-subset CPU with byte-laned tri-state data bus
module mips_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input logic       clk,
  input logic       rst,
  mips_if.master    bus,
  inout wire [31:0] DataBus
);
  logic [31:0] r_pc;
  logic [31:0] r_regs [32];
  logic [31:0] w_ins, w_rsv, w_rtv, w_sext, w_imm, w_pc4, w_alu_b, w_alu_y;
  logic [31:0] w_ld, w_st, w_next_pc, w_wr_data;
  logic [5:0]  w_opc, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_wr_addr;
  logic [3:0]  w_lanes;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [1:0]  w_size;
  logic        w_zext, w_use_imm, w_wr_en, w_load, w_store, w_uns, w_jal;
  alu_op_t     w_alu_op;
  rdec_t       w_rdec;
  assign w_ins = bus.Instruction;
  assign w_opc = w_ins[31:26];
  assign w_rs = w_ins[25:21];
  assign w_rt = w_ins[20:16];
  assign w_rd = w_ins[15:11];
  assign w_fn = w_ins[5:0];
  assign w_rsv = r_regs[w_rs];
  assign w_rtv = r_regs[w_rt];
  assign w_pc4 = r_pc + 32'd4;
  assign w_sext = {{16{w_ins[15]}}, w_ins[15:0]};
  assign w_rdec = rtype_dec(w_fn);
  assign w_imm = w_opc == OP_LUI ? {w_ins[15:0], 16'h0} : w_zext ? {16'h0, w_ins[15:0]} : w_sext;
  assign w_alu_b = w_use_imm ? w_imm : w_rtv;
  assign w_shamt = w_fn[2] ? w_rsv[4:0] : w_ins[10:6];
  always_comb begin
    w_alu_op = ALU_ADD;
    w_use_imm = 1'b1;
    w_zext = 1'b0;
    w_wr_en = 1'b0;
    w_wr_addr = w_rt;
    w_load = 1'b0;
    w_store = 1'b0;
    w_uns = w_opc[2];
    w_size = w_opc[1:0] == 2'b11 ? 2'd2 : {1'b0, w_opc[0]};
    w_jal = 1'b0;
    w_next_pc = w_pc4;
    case (w_opc)
      OP_RTYPE: begin
        w_use_imm = 1'b0;
        w_alu_op = w_rdec.op;
        w_wr_en = w_rdec.ok;
        w_wr_addr = w_rd;
        if (w_fn == F_JR) w_next_pc = {w_rsv[31:2], 2'b00};
      end
      OP_J: w_next_pc = {w_pc4[31:28], w_ins[25:0], 2'b00};
      OP_JAL: begin
        w_next_pc = {w_pc4[31:28], w_ins[25:0], 2'b00};
        w_jal = 1'b1;
        w_wr_en = 1'b1;
        w_wr_addr = 5'd31;
      end
      OP_BEQ: w_next_pc = w_rsv == w_rtv ? w_pc4 + (w_sext << 2) : w_pc4;
      OP_BNE: w_next_pc = w_rsv != w_rtv ? w_pc4 + (w_sext << 2) : w_pc4;
      OP_ADDI, OP_ADDIU: w_wr_en = 1'b1;
      OP_SLTI: begin w_alu_op = ALU_SLT; w_wr_en = 1'b1; end
      OP_SLTIU: begin w_alu_op = ALU_SLTU; w_wr_en = 1'b1; end
      OP_ANDI: begin w_alu_op = ALU_AND; w_zext = 1'b1; w_wr_en = 1'b1; end
      OP_ORI: begin w_alu_op = ALU_OR; w_zext = 1'b1; w_wr_en = 1'b1; end
      OP_XORI: begin w_alu_op = ALU_XOR; w_zext = 1'b1; w_wr_en = 1'b1; end
      OP_LUI: begin w_alu_op = ALU_PASSB; w_wr_en = 1'b1; end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin w_load = 1'b1; w_wr_en = 1'b1; end
      OP_SB, OP_SH, OP_SW: w_store = 1'b1;
      default: ;
    endcase
  end
  mips_alu u_alu (.a(w_rsv), .b(w_alu_b), .shamt(w_shamt), .op(w_alu_op), .y(w_alu_y));
  // Big-endian lanes: address byte 0 lives on DataBus[31:24].
  assign w_lanes = !w_store ? 4'b0000 : w_size == 2'd2 ? 4'b1111 :
                   w_size == 2'd1 ? (w_alu_y[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> w_alu_y[1:0];
  assign w_st = w_size == 2'd2 ? w_rtv : w_size == 2'd1 ? {2{w_rtv[15:0]}} : {4{w_rtv[7:0]}};
  assign w_byte = 8'(DataBus >> {~w_alu_y[1:0], 3'b000});
  assign w_half = w_alu_y[1] ? DataBus[15:0] : DataBus[31:16];
  assign w_ld = w_size == 2'd2 ? DataBus : w_size == 2'd1 ? {{16{~w_uns & w_half[15]}}, w_half} :
                {{24{~w_uns & w_byte[7]}}, w_byte};
  assign w_wr_data = w_jal ? w_pc4 : w_load ? w_ld : w_alu_y;
  assign DataBus = |w_lanes ? w_st : 'z;
  assign bus.ProgramCounter = r_pc;
  assign bus.AddressBus = w_alu_y;
  assign bus.ALUResult = w_alu_y;
  assign bus.MemRead = w_load;
  assign bus.MemWrite = w_lanes;
  assign bus.BusCycle = w_load | w_store;
  always_ff @(posedge clk)
    if (rst) begin
      r_pc <= RESET_PC;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (w_wr_en && w_wr_addr != 5'd0) r_regs[w_wr_addr] <= w_wr_data;
    end
endmodule

// File: tb/tb_mips_core.sv
// tb_mips_core: lockstep ISA-model check of mips_core on a directed plus random program
module tb_mips_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mips_if bus();
  wire [31:0] data_bus;
  logic [31:0] imem [512];
  logic [31:0] mem [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  int n_tests = 0;
  int n_fail = 0;
  localparam logic [15:0][5:0] R_FNS = {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                        6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  localparam logic [7:0][5:0] I_OPS = {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  localparam logic [4:0][5:0] L_OPS = {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  localparam logic [2:0][5:0] S_OPS = {6'h28, 6'h29, 6'h2B};
  mips_core dut (.clk(clk), .rst(rst), .bus(bus), .DataBus(data_bus));
  assign bus.Instruction = imem[bus.ProgramCounter[10:2]];
  assign data_bus = bus.MemWrite == 4'b0000 ? mem[bus.AddressBus[9:2]] : 'z;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (model pc %h)", tag, got, exp, m_pc);
    end
  endtask
  function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(logic [5:0] op, logic [31:0] target);
    return {op, target[27:2]};
  endfunction
  function automatic logic [31:0] rand_ins();
    int k;
    logic [4:0] a, b, c;
    logic [15:0] im;
    k = $urandom_range(0, 9);
    a = 5'($urandom_range(0, 15));
    b = 5'($urandom_range(0, 15));
    c = 5'($urandom_range(0, 15));
    im = 16'($urandom);
    if (k <= 3) return enc_r(R_FNS[$urandom_range(0, 15)], a, b, c, 5'($urandom));
    if (k <= 6) return enc_i(I_OPS[$urandom_range(0, 7)], a, b, im);
    if (k == 7) return enc_i(L_OPS[$urandom_range(0, 4)], 5'd0, b, 16'($urandom_range(0, 255)));
    if (k == 8) return enc_i(S_OPS[$urandom_range(0, 2)], 5'd0, b, 16'($urandom_range(0, 255)));
    return $urandom_range(0, 1) == 0 ? {6'h3F, 26'($urandom)} : enc_r(6'h01, a, b, c, 5'd0);
  endfunction
  task automatic step();
    logic [31:0] ins, rs_v, rt_v, simm, zimm, res, ae, addr, w, npc, sd;
    logic [15:0] hw;
    logic [7:0] bt;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh, dst;
    logic [3:0] lanes;
    logic wr, chk, ld, st;
    int bi;
    ins = imem[m_pc[10:2]];
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6]; fn = ins[5:0];
    rs_v = m_regs[rs]; rt_v = m_regs[rt];
    simm = {{16{ins[15]}}, ins[15:0]}; zimm = {16'h0, ins[15:0]};
    addr = rs_v + simm;
    w = mem[addr[9:2]];
    bi = 3 - int'(addr[1:0]);
    bt = w[bi*8 +: 8];
    hw = addr[1] ? w[15:0] : w[31:16];
    wr = 1'b0; chk = 1'b0; ld = 1'b0; st = 1'b0; dst = rt; res = '0; sd = '0; lanes = '0;
    npc = m_pc + 32'd4;
    case (op)
      6'h00: begin
        dst = rd; wr = 1'b1; chk = 1'b1;
        case (fn)
          6'h00: res = rt_v << sh;
          6'h02: res = rt_v >> sh;
          6'h03: res = $unsigned($signed(rt_v) >>> sh);
          6'h04: res = rt_v << rs_v[4:0];
          6'h06: res = rt_v >> rs_v[4:0];
          6'h07: res = $unsigned($signed(rt_v) >>> rs_v[4:0]);
          6'h08: begin wr = 1'b0; chk = 1'b0; npc = rs_v; end
          6'h20, 6'h21: res = rs_v + rt_v;
          6'h22, 6'h23: res = rs_v - rt_v;
          6'h24: res = rs_v & rt_v;
          6'h25: res = rs_v | rt_v;
          6'h26: res = rs_v ^ rt_v;
          6'h27: res = ~(rs_v | rt_v);
          6'h2A: res = $signed(rs_v) < $signed(rt_v) ? 32'd1 : 32'd0;
          6'h2B: res = rs_v < rt_v ? 32'd1 : 32'd0;
          default: begin wr = 1'b0; chk = 1'b0; end
        endcase
      end
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin res = m_pc + 32'd4; npc = {npc[31:28], ins[25:0], 2'b00}; wr = 1'b1; dst = 5'd31; end
      6'h04: if (rs_v == rt_v) npc = npc + simm * 4;
      6'h05: if (rs_v != rt_v) npc = npc + simm * 4;
      6'h08, 6'h09: begin res = rs_v + simm; wr = 1'b1; chk = 1'b1; end
      6'h0A: begin res = $signed(rs_v) < $signed(simm) ? 32'd1 : 32'd0; wr = 1'b1; chk = 1'b1; end
      6'h0B: begin res = rs_v < simm ? 32'd1 : 32'd0; wr = 1'b1; chk = 1'b1; end
      6'h0C: begin res = rs_v & zimm; wr = 1'b1; chk = 1'b1; end
      6'h0D: begin res = rs_v | zimm; wr = 1'b1; chk = 1'b1; end
      6'h0E: begin res = rs_v ^ zimm; wr = 1'b1; chk = 1'b1; end
      6'h0F: begin res = {ins[15:0], 16'h0}; wr = 1'b1; chk = 1'b1; end
      6'h20: begin res = {{24{bt[7]}}, bt}; ld = 1'b1; end
      6'h24: begin res = {24'h0, bt}; ld = 1'b1; end
      6'h21: begin res = {{16{hw[15]}}, hw}; ld = 1'b1; end
      6'h25: begin res = {16'h0, hw}; ld = 1'b1; end
      6'h23: begin res = w; ld = 1'b1; end
      6'h28: begin lanes = 4'b0001 << bi; sd = {4{rt_v[7:0]}}; st = 1'b1; end
      6'h29: begin lanes = addr[1] ? 4'b0011 : 4'b1100; sd = {2{rt_v[15:0]}}; st = 1'b1; end
      6'h2B: begin lanes = 4'b1111; sd = rt_v; st = 1'b1; end
      default: ;
    endcase
    if (ld) wr = 1'b1;
    ae = (ld || st) ? addr : res;
    check("pc", bus.ProgramCounter, m_pc);
    check("memread", 32'(bus.MemRead), 32'(ld));
    check("memwrite", 32'(bus.MemWrite), 32'(lanes));
    check("buscycle", 32'(bus.BusCycle), 32'(ld | st));
    if (chk || ld || st) check("aluresult", bus.ALUResult, ae);
    if (ld || st) check("addressbus", bus.AddressBus, addr);
    if (st) check("store_data", data_bus, sd);
    if (ld) check("load_bus", data_bus, w);
    if (wr && dst != 5'd0) m_regs[dst] = res;
    for (int k = 0; k < 4; k++) if (lanes[k]) mem[addr[9:2]][8*k +: 8] = sd[8*k +: 8];
    m_pc = npc;
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 512; i++) imem[i] = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = '0;
    imem[8'h00 >> 2] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[8'h04 >> 2] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[8'h08 >> 2] = enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
    imem[8'h0C >> 2] = enc_r(6'h2A, 5'd2, 5'd1, 5'd4, 5'd0);
    imem[8'h10 >> 2] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
    imem[8'h14 >> 2] = enc_i(6'h08, 5'd0, 5'd7, 16'd99);
    imem[8'h18 >> 2] = enc_i(6'h08, 5'd0, 5'd7, 16'd98);
    imem[8'h1C >> 2] = enc_i(6'h05, 5'd0, 5'd0, 16'd5);
    imem[8'h20 >> 2] = enc_j(6'h03, 32'h100);
    imem[8'h24 >> 2] = enc_i(6'h2B, 5'd0, 5'd4, 16'h10);
    imem[8'h28 >> 2] = enc_r(6'h2B, 5'd2, 5'd1, 5'd4, 5'd0);
    imem[8'h2C >> 2] = enc_i(6'h2B, 5'd0, 5'd4, 16'h14);
    imem[8'h30 >> 2] = enc_i(6'h0F, 5'd0, 5'd5, 16'h1234);
    imem[8'h34 >> 2] = enc_i(6'h0D, 5'd5, 5'd5, 16'h5678);
    imem[8'h38 >> 2] = enc_i(6'h2B, 5'd0, 5'd5, 16'h8);
    imem[8'h3C >> 2] = enc_i(6'h23, 5'd0, 5'd6, 16'h8);
    imem[8'h40 >> 2] = enc_i(6'h2B, 5'd0, 5'd6, 16'hC);
    imem[8'h44 >> 2] = enc_i(6'h28, 5'd0, 5'd5, 16'h9);
    imem[8'h48 >> 2] = enc_i(6'h08, 5'd0, 5'd8, 16'h80);
    imem[8'h4C >> 2] = enc_i(6'h28, 5'd0, 5'd8, 16'h9);
    imem[8'h50 >> 2] = enc_i(6'h20, 5'd0, 5'd9, 16'h9);
    imem[8'h54 >> 2] = enc_i(6'h24, 5'd0, 5'd10, 16'h9);
    imem[8'h58 >> 2] = enc_i(6'h2B, 5'd0, 5'd9, 16'h18);
    imem[8'h5C >> 2] = enc_i(6'h2B, 5'd0, 5'd10, 16'h1C);
    imem[8'h60 >> 2] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    imem[8'h64 >> 2] = enc_i(6'h2B, 5'd0, 5'd0, 16'h20);
    imem[8'h68 >> 2] = 32'hFC00_0000;
    imem[8'h6C >> 2] = enc_i(6'h29, 5'd0, 5'd5, 16'h22);
    imem[8'h70 >> 2] = enc_i(6'h21, 5'd0, 5'd11, 16'h22);
    imem[8'h74 >> 2] = enc_i(6'h2B, 5'd0, 5'd31, 16'h24);
    imem[8'h78 >> 2] = enc_j(6'h02, 32'h200);
    imem[9'h100 >> 2] = enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
    for (int i = 128; i < 328; i++) imem[i] = rand_ins();
    imem[328] = enc_j(6'h02, 32'h520);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pc", bus.ProgramCounter, 32'h0);
    check("reset_memread", 32'(bus.MemRead), 32'h0);
    check("reset_memwrite", 32'(bus.MemWrite), 32'h0);
    check("reset_buscycle", 32'(bus.BusCycle), 32'h0);
    check("reset_bus_released", data_bus, mem[1]);
    rst = 1'b0;
    repeat (240) step();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    check("mid_reset_pc", bus.ProgramCounter, 32'h0);
    repeat (20) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
